// File: rtl/core_lsu_wbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_wbuf_if
// Description : M2 store push bus and DRAM-manager write bus of the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_lsu_wbuf_if #(
    parameter int unsigned WAY_CNT = 1
);
    logic               push_valid_i;
    logic               push_ready_o;
    logic [31:0]        push_paddr_i;
    logic [31:0]        push_wdata_i;
    logic [3:0]         push_strobe_i;
    logic               push_uncached_i;
    logic [1:0]         push_size_i;
    logic [WAY_CNT-1:0] push_sel_i;

    logic               dm_we_valid_o;
    logic               dm_we_ready_i;
    logic [31:0]        dm_waddr_o;
    logic [31:0]        dm_wdata_o;
    logic [3:0]         dm_strobe_o;
    logic               dm_uncached_o;
    logic [1:0]         dm_size_o;
    logic [WAY_CNT-1:0] dm_we_sel_o;

    // Environment view: M2 pushes stores, DRAM manager accepts writes.
    modport master (
        output push_valid_i, push_paddr_i, push_wdata_i, push_strobe_i,
               push_uncached_i, push_size_i, push_sel_i, dm_we_ready_i,
        input  push_ready_o, dm_we_valid_o, dm_waddr_o, dm_wdata_o,
               dm_strobe_o, dm_uncached_o, dm_size_o, dm_we_sel_o
    );

    modport slave (
        input  push_valid_i, push_paddr_i, push_wdata_i, push_strobe_i,
               push_uncached_i, push_size_i, push_sel_i, dm_we_ready_i,
        output push_ready_o, dm_we_valid_o, dm_waddr_o, dm_wdata_o,
               dm_strobe_o, dm_uncached_o, dm_size_o, dm_we_sel_o
    );
endinterface
`default_nettype wire

// File: rtl/core_lsu_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_wbuf
// Description : LSU store buffer with youngest-entry merging and byte forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module core_lsu_wbuf #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WAY_CNT  = 1,
    parameter bit          MERGE_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    core_lsu_wbuf_if.slave             bus,
    input  logic [31:0]                fwd_paddr_i,
    output logic [31:0]                fwd_data_o,
    output logic [3:0]                 fwd_mask_o,
    output logic                       fwd_uncached_o,
    input  logic                       drain_req_i,
    output logic                       drain_done_o,
    output logic                       pending_write_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);

    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [DEPTH-1:0]   r_valid;

    logic [31:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [3:0]         r_strb [DEPTH];
    logic [DEPTH-1:0]   r_unc;
    logic [1:0]         r_size [DEPTH];
    logic [WAY_CNT-1:0] r_sel  [DEPTH];

    logic [c_ptr_w-1:0] w_young;
    logic               w_merge_hit;
    logic               w_push_ready;
    logic               w_alloc;
    logic               w_merge;
    logic               w_pop;
    logic [c_ptr_w-1:0] w_fwd_idx;
    logic               w_fwd_unused;

    assign w_young = r_tail - c_ptr_w'(1);

    // count >= 2 keeps the merge target away from the head, whose payload
    // must stay stable while the DRAM manager is looking at it.
    assign w_merge_hit = MERGE_EN
                      && (r_count >= c_cnt_w'(2))
                      && !r_unc[w_young]
                      && !bus.push_uncached_i
                      && (r_addr[w_young][31:2] == bus.push_paddr_i[31:2])
                      && !drain_req_i;

    assign w_push_ready = !drain_req_i && ((r_count < c_cnt_w'(DEPTH)) || w_merge_hit);
    assign w_alloc      = bus.push_valid_i && w_push_ready && !w_merge_hit;
    assign w_merge      = bus.push_valid_i && w_push_ready && w_merge_hit;
    assign w_pop        = (r_count != '0) && bus.dm_we_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_alloc) begin
                r_tail          <= r_tail + c_ptr_w'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + c_ptr_w'(1);
                r_valid[r_head] <= 1'b0;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_addr[r_tail] <= bus.push_paddr_i;
            r_data[r_tail] <= bus.push_wdata_i;
            r_strb[r_tail] <= bus.push_strobe_i;
            r_unc[r_tail]  <= bus.push_uncached_i;
            r_size[r_tail] <= bus.push_size_i;
            r_sel[r_tail]  <= bus.push_sel_i;
        end else if (w_merge) begin
            for (int s = 0; s < 4; s++) begin
                if (bus.push_strobe_i[s]) begin
                    r_data[w_young][8*s +: 8] <= bus.push_wdata_i[8*s +: 8];
                end
            end
            r_strb[w_young] <= r_strb[w_young] | bus.push_strobe_i;
        end
    end

    assign bus.push_ready_o  = w_push_ready;
    assign bus.dm_we_valid_o = (r_count != '0);
    assign bus.dm_waddr_o    = r_addr[r_head];
    assign bus.dm_wdata_o    = r_data[r_head];
    assign bus.dm_strobe_o   = r_strb[r_head];
    assign bus.dm_uncached_o = r_unc[r_head];
    assign bus.dm_size_o     = r_size[r_head];
    assign bus.dm_we_sel_o   = r_sel[r_head];

    // Walk oldest to youngest so a younger matching byte overwrites an older one.
    always_comb begin
        fwd_data_o     = '0;
        fwd_mask_o     = '0;
        fwd_uncached_o = 1'b0;
        w_fwd_idx      = r_head;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_fwd_idx = r_head + c_ptr_w'(i);
            if (r_valid[w_fwd_idx] && (r_addr[w_fwd_idx][31:2] == fwd_paddr_i[31:2])) begin
                if (r_unc[w_fwd_idx]) begin
                    fwd_uncached_o = 1'b1;
                end
                for (int s = 0; s < 4; s++) begin
                    if (r_strb[w_fwd_idx][s]) begin
                        fwd_data_o[8*s +: 8] = r_data[w_fwd_idx][8*s +: 8];
                        fwd_mask_o[s]        = 1'b1;
                    end
                end
            end
        end
    end

    assign w_fwd_unused    = ^fwd_paddr_i[1:0];
    assign drain_done_o    = drain_req_i && (r_count == '0);
    assign pending_write_o = (r_count != '0) || bus.push_valid_i;
    assign count_o         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_core_lsu_wbuf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_core_lsu_wbuf
// Description : Directed scoreboard bench for the LSU store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_lsu_wbuf;

    localparam int DEPTH = 4;
    localparam int WAY   = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   fwd_paddr;
    logic [31:0]   fwd_data;
    logic [3:0]    fwd_mask;
    logic          fwd_unc;
    logic          drain_req;
    logic          drain_done;
    logic          pending;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    core_lsu_wbuf_if #(.WAY_CNT(WAY)) bus ();

    core_lsu_wbuf #(
        .DEPTH    (DEPTH),
        .WAY_CNT  (WAY),
        .MERGE_EN (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .fwd_paddr_i     (fwd_paddr),
        .fwd_data_o      (fwd_data),
        .fwd_mask_o      (fwd_mask),
        .fwd_uncached_o  (fwd_unc),
        .drain_req_i     (drain_req),
        .drain_done_o    (drain_done),
        .pending_write_o (pending),
        .count_o         (count)
    );

    typedef struct packed {
        logic [31:0]    addr;
        logic [31:0]    data;
        logic [3:0]     strb;
        logic           unc;
        logic [1:0]     size;
        logic [WAY-1:0] sel;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_act;
    wr_t mon_exp;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic u, input logic [1:0] sz, input logic [WAY-1:0] sel);
        exp_q.push_back({a, d, s, u, sz, sel});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic u, input logic [1:0] sz, input logic [WAY-1:0] sel);
        bus.push_valid_i    = 1'b1;
        bus.push_paddr_i    = a;
        bus.push_wdata_i    = d;
        bus.push_strobe_i   = s;
        bus.push_uncached_i = u;
        bus.push_size_i     = sz;
        bus.push_sel_i      = sel;
    endtask

    // One accepted push: ready is checked mid-cycle, valid drops after the edge.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic u, input logic [1:0] sz, input logic [WAY-1:0] sel);
        drive(a, d, s, u, sz, sel);
        @(negedge clk);
        chk("push_ready", bus.push_ready_o, 1);
        step();
        bus.push_valid_i = 1'b0;
    endtask

    // Scoreboard monitor: every DRAM-manager handshake pops one expected write.
    always @(negedge clk) begin
        if (!rst && bus.dm_we_valid_o === 1'b1 && bus.dm_we_ready_i === 1'b1) begin
            mon_act = {bus.dm_waddr_o, bus.dm_wdata_o, bus.dm_strobe_o,
                       bus.dm_uncached_o, bus.dm_size_o, bus.dm_we_sel_o};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dm_write: got %h expected none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL dm_write: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.push_valid_i    = 1'b0;
        bus.push_paddr_i    = '0;
        bus.push_wdata_i    = '0;
        bus.push_strobe_i   = '0;
        bus.push_uncached_i = 1'b0;
        bus.push_size_i     = '0;
        bus.push_sel_i      = '0;
        bus.dm_we_ready_i   = 1'b0;
        fwd_paddr           = 32'h100;
        drain_req           = 1'b0;

        #2;
        chk("rst_dm_valid", bus.dm_we_valid_o, 0);
        chk("rst_push_ready", bus.push_ready_o, 1);
        chk("rst_count", count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        @(negedge clk);
        chk("idle_count", count, 0);
        chk("idle_dm_valid", bus.dm_we_valid_o, 0);
        chk("idle_push_ready", bus.push_ready_o, 1);
        chk("idle_fwd_mask", fwd_mask, 0);
        chk("idle_pending", pending, 0);
        chk("idle_drain_done", drain_done, 0);
        step();

        // One-cycle latency, then back-to-back throughput
        bus.dm_we_ready_i = 1'b1;
        drive(32'h600, 32'hDEADBEEF, 4'hF, 1'b0, 2'b10, 2'b01);
        enq(32'h600, 32'hDEADBEEF, 4'hF, 1'b0, 2'b10, 2'b01);
        @(negedge clk);
        chk("lat_push_ready", bus.push_ready_o, 1);
        chk("lat_same_cycle_valid", bus.dm_we_valid_o, 0);
        chk("lat_pending", pending, 1);
        step();
        bus.push_valid_i = 1'b0;
        @(negedge clk);
        chk("lat_next_cycle_valid", bus.dm_we_valid_o, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            enq(32'h610 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b0, 2'b10, 2'b10);
            push(32'h610 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF, 1'b0, 2'b10, 2'b10);
        end
        @(negedge clk);
        chk("stream_count", count, 1);
        step();
        @(negedge clk);
        chk("stream_empty", count, 0);
        bus.dm_we_ready_i = 1'b0;
        step();

        // Fill to DEPTH, full buffer rejects even with a same-cycle pop
        for (int i = 1; i <= 4; i++) begin
            enq(32'(i) << 8, 32'hA0000000 | (32'(i) << 8), 4'hF, 1'b0, 2'b10, WAY'(i));
            push(32'(i) << 8, 32'hA0000000 | (32'(i) << 8), 4'hF, 1'b0, 2'b10, WAY'(i));
        end
        drive(32'h500, 32'h55555555, 4'hF, 1'b0, 2'b10, 2'b01);
        bus.dm_we_ready_i = 1'b1;
        @(negedge clk);
        chk("full_push_ready", bus.push_ready_o, 0);
        chk("full_count", count, 4);
        step();
        bus.push_valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("drain_count", count, 4 - k);
            step();
        end
        @(negedge clk);
        chk("drained_count", count, 0);
        chk("drained_dm_valid", bus.dm_we_valid_o, 0);
        chk("drained_queue", exp_q.size(), 0);
        bus.dm_we_ready_i = 1'b0;
        step();

        // Merge into youngest, then an uncached store that must not merge
        enq(32'h100, 32'hCAFE0001, 4'hF, 1'b0, 2'b10, 2'b01);
        push(32'h100, 32'hCAFE0001, 4'hF, 1'b0, 2'b10, 2'b01);
        push(32'h200, 32'h000000AA, 4'b0001, 1'b0, 2'b00, 2'b10);
        push(32'h200, 32'h0000BB00, 4'b0010, 1'b0, 2'b00, 2'b10);
        enq(32'h200, 32'h0000BBAA, 4'b0011, 1'b0, 2'b00, 2'b10);
        fwd_paddr = 32'h200;
        @(negedge clk);
        chk("merge_count", count, 2);
        chk("merge_fwd_data", fwd_data, 32'h0000BBAA);
        chk("merge_fwd_mask", fwd_mask, 4'b0011);
        chk("merge_fwd_unc", fwd_unc, 0);
        step();
        enq(32'h200, 32'h00CC0000, 4'b0100, 1'b1, 2'b00, 2'b01);
        push(32'h200, 32'h00CC0000, 4'b0100, 1'b1, 2'b00, 2'b01);
        @(negedge clk);
        chk("unc_count", count, 3);
        chk("unc_fwd_unc", fwd_unc, 1);
        chk("unc_fwd_data", fwd_data, 32'h00CCBBAA);
        chk("unc_fwd_mask", fwd_mask, 4'b0111);
        step();
        bus.dm_we_ready_i = 1'b1;
        repeat (3) step();
        bus.dm_we_ready_i = 1'b0;
        @(negedge clk);
        chk("merge_drained", count, 0);
        step();

        // Same word twice with only one entry buffered: no merge into the head
        enq(32'h80, 32'h11223344, 4'hF, 1'b0, 2'b10, 2'b01);
        push(32'h80, 32'h11223344, 4'hF, 1'b0, 2'b10, 2'b01);
        enq(32'h80, 32'h000000FF, 4'b0001, 1'b0, 2'b00, 2'b01);
        push(32'h80, 32'h000000FF, 4'b0001, 1'b0, 2'b00, 2'b01);
        fwd_paddr = 32'h80;
        @(negedge clk);
        chk("ovl_count", count, 2);
        chk("ovl_fwd_data", fwd_data, 32'h112233FF);
        chk("ovl_fwd_mask", fwd_mask, 4'hF);
        fwd_paddr = 32'h84;
        #1;
        chk("miss_fwd_mask", fwd_mask, 0);
        chk("miss_fwd_data", fwd_data, 0);
        step();

        // Drain barrier over the two entries above
        drain_req = 1'b1;
        bus.dm_we_ready_i = 1'b1;
        drive(32'h900, 32'h99999999, 4'hF, 1'b0, 2'b10, 2'b01);
        @(negedge clk);
        chk("bar_push_ready", bus.push_ready_o, 0);
        chk("bar_done_2", drain_done, 0);
        chk("bar_pending", pending, 1);
        step();
        @(negedge clk);
        chk("bar_count_1", count, 1);
        chk("bar_done_1", drain_done, 0);
        step();
        @(negedge clk);
        chk("bar_count_0", count, 0);
        chk("bar_done_0", drain_done, 1);
        step();
        bus.push_valid_i = 1'b0;
        drain_req = 1'b0;
        bus.dm_we_ready_i = 1'b0;
        @(negedge clk);
        chk("bar_released", drain_done, 0);
        chk("bar_blocked_push", count, 0);
        step();

        // Asynchronous reset with three stores buffered
        push(32'hA00, 32'h0A0A0A0A, 4'hF, 1'b0, 2'b10, 2'b01);
        push(32'hB00, 32'h0B0B0B0B, 4'hF, 1'b0, 2'b10, 2'b01);
        push(32'hC00, 32'h0C0C0C0C, 4'hF, 1'b0, 2'b10, 2'b01);
        fwd_paddr = 32'hA00;
        @(negedge clk);
        chk("pre_rst_count", count, 3);
        chk("pre_rst_dm_valid", bus.dm_we_valid_o, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_dm_valid", bus.dm_we_valid_o, 0);
        chk("async_count", count, 0);
        chk("async_push_ready", bus.push_ready_o, 1);
        chk("async_fwd_mask", fwd_mask, 0);
        bus.dm_we_ready_i = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_dm_valid", bus.dm_we_valid_o, 0);
        chk("post_rst_count", count, 0);
        step();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
